vector_line_fifo: RTL and testbench
===================================

VECTOR_LINE_FIFO -- requirements
Module: vector_line_fifo

Interface
REQ-001 SHALL accept parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-002 SHALL accept parameter COORD_W, default 13, width of each coordinate field.
REQ-003 SHALL accept parameter COLOR_W, default 3, width of the color field.
REQ-004 SHALL accept parameter AFULL_LEVEL, default 12, occupancy at or above which almost_full asserts; range 1..DEPTH.
REQ-005 SHALL accept parameter EDGE_WR, default 1; 1 = write on rising edge of wr_req, 0 = write on every cycle wr_req is high.
REQ-006 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_b, input, 1, synchronous active-low reset.
REQ-008 SHALL have port wr_req, input, 1, line write request.
REQ-009 SHALL have ports wr_start_x, wr_end_x, wr_start_y, wr_end_y, input, COORD_W each, line endpoints to store.
REQ-010 SHALL have port wr_color, input, COLOR_W, line color to store.
REQ-011 SHALL have port rd_en, input, 1, pop the head entry.
REQ-012 SHALL have port flush, input, 1, discard all stored entries.
REQ-013 SHALL have ports rd_start_x, rd_end_x, rd_start_y, rd_end_y, output, COORD_W each, plus rd_color, output, COLOR_W; these carry the head entry.
REQ-014 SHALL have port rd_valid, output, 1, high when count > 0.
REQ-015 SHALL have ports full and almost_full, output, 1 each.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-017 SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-018 SHALL define a write event (wr_evt) as wr_req && !wr_req_q when EDGE_WR=1, and as wr_req when EDGE_WR=0; wr_req_q is the wr_req value from the previous cycle.
REQ-019 SHALL present the head entry combinationally on the rd_* outputs (show-ahead, zero read latency); rd_* outputs SHALL be all-zero when count == 0.
REQ-020 SHALL accept wr_evt when count < DEPTH and store the entry at the write pointer; count +1 on the next edge.
REQ-021 SHALL advance the read pointer on rd_en when count > 0; count -1 on the next edge.
REQ-022 SHALL accept both operations when wr_evt and rd_en occur together with 0 < count < DEPTH; count unchanged, both pointers advance.
REQ-023 SHALL accept both operations when wr_evt and rd_en occur together at count == DEPTH; head pops, new entry lands in the freed slot, count stays DEPTH, overflow not set.
REQ-024 SHALL accept the write and ignore the read when wr_evt and rd_en occur together at count == 0; count becomes 1 and underflow sets.
REQ-025 SHALL drop the entry on wr_evt without rd_en at count == DEPTH, leave state unchanged, and set overflow.
REQ-026 SHALL set underflow on rd_en at count == 0 with no wr_evt.
REQ-027 SHALL wrap both pointers modulo DEPTH.
REQ-028 SHALL give flush priority over wr_evt and rd_en in the same cycle: pointers and count go to 0, overflow and underflow clear, and the write and read are discarded.
REQ-029 SHALL leave wr_req_q updating during flush, so a wr_req held high across a flush does not create a new edge event.
REQ-030 SHALL drive full = (count == DEPTH) and almost_full = (count >= AFULL_LEVEL), both combinational from count.
REQ-031 SHALL not require storage contents to be reset; unread contents are don't-care, masked by REQ-019.

Reset
REQ-032 SHALL, while rst_b == 0 at a clock edge, clear both pointers, count, overflow, underflow and wr_req_q to 0.
REQ-033 SHALL, after reset, show rd_valid=0, full=0, almost_full=0, count=0, all rd_* outputs 0.
REQ-034 SHALL give reset priority over flush, wr_evt and rd_en, including mid-operation; an in-flight write in a reset cycle is not stored.

Verification
REQ-035 SHALL cover edge mode (EDGE_WR=1): wr_req held high 5 cycles with start_x=0x0A5 -> count=1, rd_start_x=0x0A5, rd_valid=1.
REQ-036 SHALL cover fill and overflow (DEPTH=16, EDGE_WR=0): 16 writes of start_x=0..15 -> full=1, almost_full=1 from count 12; 17th write -> count 16, overflow=1; 16 pops return 0..15 in order.
REQ-037 SHALL cover full with simultaneous ops: at count 16, wr_evt and rd_en together with start_x=0x1FF -> count 16, overflow=0; after 15 pops the head is 0x1FF.
REQ-038 SHALL cover empty with simultaneous ops: at count 0, wr_evt and rd_en together -> count 1, underflow=1, rd_valid=1.
REQ-039 SHALL cover flush and wrap: 10 writes, 7 pops, 10 writes (pointers wrap), then flush together with wr_evt -> count 0, flags 0, rd_* = 0.
REQ-040 SHALL cover reset mid-operation: rst_b low for 1 cycle at count 9 with wr_evt -> count 0, rd_valid 0; the next write lands at slot 0.

Source files
------------

// File: rtl/vector_line_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vector_line_fifo
// Description : Show-ahead FIFO of vector line descriptors (two endpoints plus
//               color). Edge- or level-triggered writes, flush, sticky
//               overflow/underflow flags, full/almost-full status.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_line_fifo #(
   parameter int DEPTH       = 16,
   parameter int COORD_W     = 13,
   parameter int COLOR_W     = 3,
   parameter int AFULL_LEVEL = 12,
   parameter int EDGE_WR     = 1
) (
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic                       wr_req,
   input  logic [COORD_W-1:0]         wr_start_x,
   input  logic [COORD_W-1:0]         wr_end_x,
   input  logic [COORD_W-1:0]         wr_start_y,
   input  logic [COORD_W-1:0]         wr_end_y,
   input  logic [COLOR_W-1:0]         wr_color,
   input  logic                       rd_en,
   input  logic                       flush,
   output logic [COORD_W-1:0]         rd_start_x,
   output logic [COORD_W-1:0]         rd_end_x,
   output logic [COORD_W-1:0]         rd_start_y,
   output logic [COORD_W-1:0]         rd_end_y,
   output logic [COLOR_W-1:0]         rd_color,
   output logic                       rd_valid,
   output logic                       full,
   output logic                       almost_full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 4 * COORD_W + COLOR_W;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_req_q;
   logic          wr_evt;
   logic          is_empty;
   logic          is_full;
   logic          do_wr;
   logic          do_rd;
   logic          ovf_set;
   logic          unf_set;
   logic [EW-1:0] wr_data;
   logic [EW-1:0] head;

   // Write-event qualification: rising edge of wr_req, or plain level.
   generate
      if (EDGE_WR != 0) begin : g_edge_wr
         assign wr_evt = wr_req & ~wr_req_q;
      end else begin : g_level_wr
         assign wr_evt = wr_req;
      end
   endgenerate

   assign wr_data  = {wr_start_x, wr_end_x, wr_start_y, wr_end_y, wr_color};
   assign is_empty = (count == '0);
   assign is_full  = (count == CW'(DEPTH));

   // A read frees a slot at full, so a simultaneous write is still accepted;
   // at empty the write goes in but the read has nothing to pop.
   assign do_rd   = rd_en & ~is_empty;
   assign do_wr   = wr_evt & (~is_full | rd_en);
   assign ovf_set = wr_evt & is_full & ~rd_en;
   assign unf_set = rd_en & is_empty;

   // Pointers, occupancy, sticky flags and edge-detect history.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         wr_req_q  <= 1'b0;
      end else begin
         // History keeps tracking through flush so a held request is no new edge.
         wr_req_q <= wr_req;
         if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
            if (ovf_set) overflow  <= 1'b1;
            if (unf_set) underflow <= 1'b1;
         end
      end
   end

   // Entry storage; contents need no reset since empty slots are masked.
   always_ff @(posedge clk) begin
      if (rst_b && !flush && do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Show-ahead head entry, forced to zero while empty.
   always_comb begin
      head = '0;
      if (!is_empty) head = mem[rd_ptr];
   end

   assign {rd_start_x, rd_end_x, rd_start_y, rd_end_y, rd_color} = head;
   assign rd_valid    = ~is_empty;
   assign full        = is_full;
   assign almost_full = (count >= CW'(AFULL_LEVEL));

endmodule
`default_nettype wire

// File: tb/tb_vector_line_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_line_fifo
// Description : Self-checking bench for vector_line_fifo. Runs an edge-mode
//               and a level-mode instance side by side against a queue-based
//               reference model, with directed scenarios then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_line_fifo;

   localparam int DEPTH   = 16;
   localparam int COORD_W = 13;
   localparam int COLOR_W = 3;
   localparam int AFULL   = 12;
   localparam int CW      = $clog2(DEPTH) + 1;
   localparam int EW      = 4 * COORD_W + COLOR_W;

   typedef logic [EW-1:0] ent_t;

   logic               clk = 1'b0;
   logic               rst_b = 1'b0;
   logic               wr_req = 1'b0;
   logic               rd_en = 1'b0;
   logic               flush = 1'b0;
   logic [COORD_W-1:0] wsx = '0, wex = '0, wsy = '0, wey = '0;
   logic [COLOR_W-1:0] wcol = '0;

   // Index 0: EDGE_WR=1 instance, index 1: EDGE_WR=0 instance.
   logic [COORD_W-1:0] sx [2], ex [2], sy [2], ey [2];
   logic [COLOR_W-1:0] col [2];
   logic               vld [2], ful [2], afl [2], ovf [2], unf [2];
   logic [CW-1:0]      cnt [2];

   int checks = 0;
   int errors = 0;

   // Reference model state.
   ent_t mq [2][$];
   logic m_ovf [2];
   logic m_unf [2];
   logic m_prev;

   always #5 clk = ~clk;

   vector_line_fifo #(
      .DEPTH(DEPTH), .COORD_W(COORD_W), .COLOR_W(COLOR_W),
      .AFULL_LEVEL(AFULL), .EDGE_WR(1)
   ) dut_edge (
      .clk(clk), .rst_b(rst_b), .wr_req(wr_req),
      .wr_start_x(wsx), .wr_end_x(wex), .wr_start_y(wsy), .wr_end_y(wey),
      .wr_color(wcol), .rd_en(rd_en), .flush(flush),
      .rd_start_x(sx[0]), .rd_end_x(ex[0]), .rd_start_y(sy[0]), .rd_end_y(ey[0]),
      .rd_color(col[0]), .rd_valid(vld[0]), .full(ful[0]),
      .almost_full(afl[0]), .count(cnt[0]),
      .overflow(ovf[0]), .underflow(unf[0])
   );

   vector_line_fifo #(
      .DEPTH(DEPTH), .COORD_W(COORD_W), .COLOR_W(COLOR_W),
      .AFULL_LEVEL(AFULL), .EDGE_WR(0)
   ) dut_level (
      .clk(clk), .rst_b(rst_b), .wr_req(wr_req),
      .wr_start_x(wsx), .wr_end_x(wex), .wr_start_y(wsy), .wr_end_y(wey),
      .wr_color(wcol), .rd_en(rd_en), .flush(flush),
      .rd_start_x(sx[1]), .rd_end_x(ex[1]), .rd_start_y(sy[1]), .rd_end_y(ey[1]),
      .rd_color(col[1]), .rd_valid(vld[1]), .full(ful[1]),
      .almost_full(afl[1]), .count(cnt[1]),
      .overflow(ovf[1]), .underflow(unf[1])
   );

   task automatic chk(input string tag, input int id, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, id, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      ent_t e;
      logic evt;
      int   n;
      e = {wsx, wex, wsy, wey, wcol};
      for (int id = 0; id < 2; id++) begin
         if (!rst_b) begin
            mq[id].delete();
            m_ovf[id] = 1'b0;
            m_unf[id] = 1'b0;
         end else if (flush) begin
            mq[id].delete();
            m_ovf[id] = 1'b0;
            m_unf[id] = 1'b0;
         end else begin
            evt = (id == 0) ? (wr_req && !m_prev) : wr_req;
            n   = mq[id].size();
            if (evt && rd_en) begin
               if (n == 0) m_unf[id] = 1'b1;
               else void'(mq[id].pop_front());
               mq[id].push_back(e);
            end else if (evt) begin
               if (n < DEPTH) mq[id].push_back(e);
               else m_ovf[id] = 1'b1;
            end else if (rd_en) begin
               if (n > 0) void'(mq[id].pop_front());
               else m_unf[id] = 1'b1;
            end
         end
      end
      m_prev = rst_b ? wr_req : 1'b0;
   endtask

   task automatic check_all();
      int   n;
      ent_t h;
      for (int id = 0; id < 2; id++) begin
         n = mq[id].size();
         h = (n > 0) ? mq[id][0] : '0;
         chk("count", id, 64'(cnt[id]), 64'(n));
         chk("rd_valid", id, 64'(vld[id]), 64'(n > 0));
         chk("full", id, 64'(ful[id]), 64'(n == DEPTH));
         chk("almost_full", id, 64'(afl[id]), 64'(n >= AFULL));
         chk("overflow", id, 64'(ovf[id]), 64'(m_ovf[id]));
         chk("underflow", id, 64'(unf[id]), 64'(m_unf[id]));
         chk("head", id, 64'({sx[id], ex[id], sy[id], ey[id], col[id]}), 64'(h));
      end
   endtask

   // Apply one cycle of stimulus, clock it, then compare after the edge.
   task automatic step(input logic w, input logic r, input logic f,
                       input logic rb, input logic [COORD_W-1:0] start_x);
      wr_req = w;
      rd_en  = r;
      flush  = f;
      rst_b  = rb;
      wsx    = start_x;
      wex    = COORD_W'($urandom);
      wsy    = COORD_W'($urandom);
      wey    = COORD_W'($urandom);
      wcol   = COLOR_W'($urandom);
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      m_prev = 1'b0;
      for (int id = 0; id < 2; id++) begin
         m_ovf[id] = 1'b0;
         m_unf[id] = 1'b0;
      end

      // Reset state.
      step(1'b1, 1'b1, 1'b0, 1'b0, 13'h1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 13'h2);

      // Edge mode: wr_req held for 5 cycles yields one entry.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 13'h0A5);
      chk("edge_once_sx", 0, 64'(sx[0]), 64'h0A5);
      chk("edge_once_cnt", 0, 64'(cnt[0]), 64'd1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 13'h0);

      // Fill to full with 16 level writes, then a 17th overflows.
      for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0, 1'b1, COORD_W'(i));
      chk("lvl_overflow", 1, 64'(ovf[1]), 64'd1);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 13'h0);

      // Full with simultaneous write and read.
      step(1'b0, 1'b0, 1'b1, 1'b1, 13'h0);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b1, COORD_W'(i + 32));
      step(1'b1, 1'b1, 1'b0, 1'b1, 13'h1FF);
      for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 13'h0);
      chk("full_rw_head", 1, 64'(sx[1]), 64'h1FF);

      // Empty with simultaneous write and read.
      step(1'b0, 1'b0, 1'b1, 1'b1, 13'h0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 13'h077);

      // Flush and pointer wrap; flush wins over a concurrent write.
      step(1'b0, 1'b0, 1'b1, 1'b1, 13'h0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b1, COORD_W'(i + 64));
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 13'h0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b1, COORD_W'(i + 96));
      step(1'b1, 1'b1, 1'b1, 1'b1, 13'h155);
      // Held request across flush must not create a new edge-mode write.
      step(1'b1, 1'b0, 1'b0, 1'b1, 13'h156);
      step(1'b0, 1'b0, 1'b0, 1'b1, 13'h0);

      // Reset mid-operation with a write in flight.
      step(1'b0, 1'b0, 1'b1, 1'b1, 13'h0);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b1, COORD_W'(i + 128));
      step(1'b1, 1'b0, 1'b0, 1'b0, 13'h0EE);
      step(1'b1, 1'b0, 1'b0, 1'b1, 13'h0AB);
      step(1'b0, 1'b0, 1'b0, 1'b1, 13'h0);
      chk("post_rst_head", 1, 64'(sx[1]), 64'h0AB);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) < 40),
              ($urandom_range(0, 99) < 3),
              ($urandom_range(0, 99) >= 2),
              COORD_W'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
